// File: rtl/store_align.sv
// store_align: store-path alignment and sequencing for the data-memory write port.
// Accepts one SB/SH/SW request per handshake, lane-aligns data, generates byte
// strobes and issues one or two word-aligned write beats (two when the store
// crosses a word boundary).
//
// Ports:
//   clk, rstN                 clock, asynchronous active-low reset
//   storeValid / storeReady   request handshake (ready only while idle)
//   storeCtrl                 3'b000 SB, 3'b001 SH, 3'b010 SW, others illegal
//   storeAddr, storeData      byte address and register data of the store
//   memReq / memAck           write beat valid / beat accepted
//   memAddr, memWData, memWStrb  registered beat address, data, byte strobes
//   storeDone                 one-cycle pulse when the final beat is acked
//   storeErr                  one-cycle pulse after an illegal request is accepted
module store_align (
  input  logic        clk,
  input  logic        rstN,
  input  logic        storeValid,
  output logic        storeReady,
  input  logic [2:0]  storeCtrl,
  input  logic [31:0] storeAddr,
  input  logic [31:0] storeData,
  output logic        memReq,
  input  logic        memAck,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  output logic [3:0]  memWStrb,
  output logic        storeDone,
  output logic        storeErr
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_nxt, wdata_nxt;
  logic [3:0]  strb_nxt;
  logic        done_nxt, err_nxt;

  // Second-beat fields, prepared at accept time and loaded onto the bus on beat-0 ack.
  logic [31:0] hi_addr, hi_data, hi_addr_nxt, hi_data_nxt;
  logic [3:0]  hi_strb, hi_strb_nxt;

  logic        legal;
  logic [3:0]  base;
  logic [31:0] keep;
  logic [1:0]  off;
  logic [7:0]  mask8;
  logic [63:0] data64;
  logic [31:0] word_addr;

  assign storeReady = (state == IDLE);
  assign memReq     = (state != IDLE);

  always_comb begin
    legal = 1'b1;
    base  = '0;
    keep  = '0;
    case (storeCtrl)
      3'b000:  begin base = 4'b0001; keep = 32'h0000_00FF; end
      3'b001:  begin base = 4'b0011; keep = 32'h0000_FFFF; end
      3'b010:  begin base = 4'b1111; keep = 32'hFFFF_FFFF; end
      default: legal = 1'b0;
    endcase
    off       = storeAddr[1:0];
    mask8     = {4'b0000, base} << off;
    // Unused bytes are masked before the shift so unstrobed lanes read as zero.
    data64    = {32'h0, storeData & keep} << {off, 3'b000};
    word_addr = {storeAddr[31:2], 2'b00};
  end

  always_comb begin
    state_nxt   = state;
    addr_nxt    = memAddr;
    wdata_nxt   = memWData;
    strb_nxt    = memWStrb;
    hi_addr_nxt = hi_addr;
    hi_data_nxt = hi_data;
    hi_strb_nxt = hi_strb;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (storeValid) begin
          if (legal) begin
            state_nxt   = BEAT0;
            addr_nxt    = word_addr;
            strb_nxt    = mask8[3:0];
            wdata_nxt   = data64[31:0];
            hi_addr_nxt = word_addr + 32'd4;
            hi_strb_nxt = mask8[7:4];
            hi_data_nxt = data64[63:32];
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      BEAT0: begin
        if (memAck) begin
          if (hi_strb != 4'b0000) begin
            state_nxt = BEAT1;
            addr_nxt  = hi_addr;
            strb_nxt  = hi_strb;
            wdata_nxt = hi_data;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (memAck) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      memAddr   <= '0;
      memWData  <= '0;
      memWStrb  <= '0;
      hi_addr   <= '0;
      hi_data   <= '0;
      hi_strb   <= '0;
      storeDone <= 1'b0;
      storeErr  <= 1'b0;
    end else begin
      state     <= state_nxt;
      memAddr   <= addr_nxt;
      memWData  <= wdata_nxt;
      memWStrb  <= strb_nxt;
      hi_addr   <= hi_addr_nxt;
      hi_data   <= hi_data_nxt;
      hi_strb   <= hi_strb_nxt;
      storeDone <= done_nxt;
      storeErr  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_store_align.sv
// tb_store_align: self-checking bench for store_align. Expected beats come from a
// byte-by-byte reference model, are queued when a store is driven and popped as
// the DUT presents and completes each beat.
module tb_store_align;

  logic        clk = 1'b0;
  logic        rstN;
  logic        storeValid;
  logic        storeReady;
  logic [2:0]  storeCtrl;
  logic [31:0] storeAddr;
  logic [31:0] storeData;
  logic        memReq;
  logic        memAck;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic [3:0]  memWStrb;
  logic        storeDone;
  logic        storeErr;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } beat_t;

  beat_t exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  store_align dut (
    .clk        (clk),
    .rstN       (rstN),
    .storeValid (storeValid),
    .storeReady (storeReady),
    .storeCtrl  (storeCtrl),
    .storeAddr  (storeAddr),
    .storeData  (storeData),
    .memReq     (memReq),
    .memAck     (memAck),
    .memAddr    (memAddr),
    .memWData   (memWData),
    .memWStrb   (memWStrb),
    .storeDone  (storeDone),
    .storeErr   (storeErr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: place each store byte at its own address and sort by word.
  task automatic push_expected(input logic [2:0] ctrl, input logic [31:0] addr,
                               input logic [31:0] data);
    beat_t       b0, b1;
    int unsigned nb;
    logic [31:0] w0, a;
    logic [1:0]  lane;
    nb = (ctrl == 3'b000) ? 1 : (ctrl == 3'b001) ? 2 : 4;
    w0 = addr & 32'hFFFF_FFFC;
    b0 = '0;
    b1 = '0;
    b0.addr = w0;
    b1.addr = w0 + 32'd4;
    for (int unsigned i = 0; i < nb; i++) begin
      a    = addr + i;
      lane = a[1:0];
      if ((a & 32'hFFFF_FFFC) == w0) begin
        b0.strb[lane] = 1'b1;
        b0.data[{lane, 3'b000} +: 8] = data[8*i +: 8];
      end else begin
        b1.strb[lane] = 1'b1;
        b1.data[{lane, 3'b000} +: 8] = data[8*i +: 8];
      end
    end
    exp_q.push_back(b0);
    if (b1.strb != 4'b0000) exp_q.push_back(b1);
  endtask

  // Called and returns at a falling edge.
  task automatic do_store(input logic [2:0] ctrl, input logic [31:0] addr,
                          input logic [31:0] data, input int unsigned delay);
    logic        legal;
    logic [31:0] r;
    legal = (ctrl == 3'b000) || (ctrl == 3'b001) || (ctrl == 3'b010);
    if (legal) push_expected(ctrl, addr, data);
    storeValid = 1'b1;
    storeCtrl  = ctrl;
    storeAddr  = addr;
    storeData  = data;
    @(negedge clk);
    // Scramble request inputs so the DUT must rely on its captured copy.
    storeValid = 1'b0;
    r = $urandom; storeCtrl = r[2:0];
    storeAddr = $urandom;
    storeData = $urandom;
    if (!legal) begin
      check("err_pulse", {storeErr, storeDone, memReq, storeReady}, 4'b1001);
      @(negedge clk);
      check("err_clear", {storeErr, storeDone, memReq, storeReady}, 4'b0001);
      return;
    end
    check("busy", storeReady, 1'b0);
    while (exp_q.size() > 0) begin
      for (int unsigned k = 0; k <= delay; k++) begin
        check("beat_req", memReq, 1'b1);
        check("beat_no_done", storeDone, 1'b0);
        check("beat_addr", memAddr, exp_q[0].addr);
        check("beat_strb", memWStrb, exp_q[0].strb);
        check("beat_wdata", memWData, exp_q[0].data);
        memAck = (k == delay);
        @(negedge clk);
      end
      memAck = 1'b0;
      void'(exp_q.pop_front());
    end
    check("done", {memReq, storeDone, storeReady}, 3'b011);
    @(negedge clk);
    check("done_clear", {storeDone, storeErr}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    rstN       = 1'b0;
    storeValid = 1'b0;
    storeCtrl  = '0;
    storeAddr  = '0;
    storeData  = '0;
    memAck     = 1'b0;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_ctl", {storeReady, memReq, storeDone, storeErr, memWStrb}, 8'h80);
      check("rst_addr", memAddr, 32'h0);
      check("rst_wdata", memWData, 32'h0);
    end

    do_store(3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 0);
    do_store(3'b000, 32'h0000_0203, 32'h0000_00A5, 0);
    do_store(3'b001, 32'h0000_0202, 32'h0000_1234, 0);
    do_store(3'b010, 32'h0000_0101, 32'h1122_3344, 0);
    do_store(3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF, 3);
    do_store(3'b111, 32'h0000_0040, 32'hCAFE_F00D, 0);
    do_store(3'b000, 32'h0000_0047, 32'hFFFF_FF5A, 1);

    // Abort a split store while its first beat is stalled.
    storeValid = 1'b1;
    storeCtrl  = 3'b010;
    storeAddr  = 32'h0000_0105;
    storeData  = 32'h5566_7788;
    @(negedge clk);
    storeValid = 1'b0;
    check("abort_pre_req", memReq, 1'b1);
    #2 rstN = 1'b0;
    #1 check("abort_async", {memReq, storeDone, storeReady}, 3'b001);
    @(negedge clk);
    check("abort_hold", {memReq, storeDone, storeErr, storeReady}, 4'b0001);
    rstN = 1'b1;
    @(negedge clk);
    check("abort_after", {memReq, storeDone, storeErr, storeReady}, 4'b0001);
    do_store(3'b010, 32'h0000_0102, 32'hA1B2_C3D4, 1);

    for (int i = 0; i < 10; i++) begin
      r = $urandom_range(0, 2);
      do_store(r[2:0], $urandom, $urandom, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_align.md
# store_align

Store-path alignment and sequencing unit for the core's data-memory write port. It accepts one store request (SB/SH/SW) per handshake and positions the store data on the 32-bit word bus. It generates per-byte write strobes and issues one or two word-aligned memory write beats. A store whose bytes cross a word boundary is split into two beats. It sits between the execute/memory stage and the data-memory write interface, as the write-side counterpart of the load-extension path.

## Interface
- No parameters; address and data widths are fixed at 32 bits.
- clk  in  1  core clock, rising-edge active
- rstN  in  1  asynchronous, active-low reset
- storeValid  in  1  store request valid
- storeReady  out  1  unit can accept a request (high only in IDLE)
- storeCtrl  in  3  store type: SB=3'b000, SH=3'b001, SW=3'b010; all other codes are illegal
- storeAddr  in  32  byte address of the store
- storeData  in  32  register data; SB uses [7:0], SH uses [15:0]
- memReq  out  1  write beat valid
- memAck  in  1  memory accepted the current beat
- memAddr  out  32  word-aligned beat address, with [1:0] always 2'b00
- memWData  out  32  lane-aligned write data
- memWStrb  out  4  byte strobes, bit i enables byte lane i
- storeDone  out  1  one-cycle pulse when a store completes
- storeErr  out  1  one-cycle pulse when an illegal storeCtrl is accepted

## Operation
- States: IDLE, BEAT0, BEAT1.
- Accept condition: storeValid && storeReady in IDLE. On acceptance, capture storeCtrl, storeAddr and storeData.
- Base strobe by type: SB=4'b0001, SH=4'b0011, SW=4'b1111.
- Let off = storeAddr[1:0].
  - 8-bit strobe: mask8 = {4'b0, base} << off.
  - 64-bit data: data64 = {32'b0, storeData} << (8*off).
- Beat 0:
  - memAddr = {storeAddr[31:2], 2'b00}
  - memWStrb = mask8[3:0]
  - memWData = data64[31:0]
- Beat 1 is needed only when mask8[7:4] != 0, for example SH at off=3 or SW at off≠0:
  - memAddr = beat-0 address + 4, modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000
  - memWStrb = mask8[7:4]
  - memWData = data64[63:32]
- Bytes in memWData lanes whose strobe is 0 are driven 0.
- Transitions:
  - IDLE→BEAT0 on a legal accept.
  - BEAT0→BEAT1 on memAck when a split is needed.
  - BEAT0→IDLE on memAck when no split is needed; pulse storeDone.
  - BEAT1→IDLE on memAck; pulse storeDone.
- Illegal storeCtrl: the request is accepted, no memReq is issued, and the unit stays in IDLE. storeErr pulses the next cycle and storeDone stays low.
- memReq is high in BEAT0/BEAT1 and low in IDLE.
- memAddr, memWData and memWStrb are registered and hold stable while memReq && !memAck.
- memAck is ignored while memReq is low.

## Timing
- Reset (rstN low, asynchronous): state IDLE, with the following output values:
  - storeReady=1
  - memReq=0
  - memAddr=0, memWData=0, memWStrb=0
  - storeDone=0, storeErr=0
- Reset asserted mid-transaction aborts the store immediately. memReq drops without waiting for memAck, and no storeDone is issued.
- Accept at edge N: memReq=1 with beat-0 outputs from cycle N+1.
- memAck is sampled at each rising edge while memReq=1. A zero-wait memory asserts memAck in the first memReq cycle:
  - single-beat store: 1 memReq cycle
  - split store: 2 consecutive memReq cycles
- Final memAck sampled at edge M:
  - at M+1, memReq=0, storeDone=1 for exactly one cycle, storeReady=1
  - a new request may be accepted at edge M+1, giving back-to-back throughput of one single-beat store per 2 cycles
- Illegal accept at edge N: storeErr=1 during cycle N+1, storeReady stays 1.
- storeDone and storeErr are registered outputs and are never high together.

## Test plan
- Reset release, no stimulus: storeReady=1, memReq=0, all other outputs 0, and they hold at these values for 10 cycles.
- SW, addr=0x00001000, data=0xDEADBEEF, zero-wait ack:
  - one beat: memAddr=0x00001000, memWStrb=4'b1111, memWData=0xDEADBEEF
  - storeDone pulses once
- SB, addr=0x00000203, data=0x000000A5; SH, addr=0x00000202, data=0x00001234:
  - SB gives strobe 4'b1000, wdata 0xA5000000
  - SH gives strobe 4'b1100, wdata 0x12340000
  - each is a single beat
- SW, addr=0x00000101, data=0x11223344:
  - beat0: memAddr=0x00000100, strb 4'b1110, wdata 0x22334400
  - beat1: memAddr=0x00000104, strb 4'b0001, wdata 0x00000011
  - storeDone only after beat-1 ack
- SH, addr=0xFFFFFFFF, data=0x0000BEEF, memAck delayed 3 cycles per beat:
  - beat0 outputs stable while stalled: addr 0xFFFFFFFC, strb 4'b1000, wdata 0xEF000000
  - beat1: addr 0x00000000, strb 4'b0001, wdata 0x000000BE
- storeCtrl=3'b111: no memReq, storeErr pulses once, storeDone stays 0.
- Reset mid-BEAT0 of a split store:
  - memReq falls asynchronously, no storeDone
  - next store after release behaves normally
